// File: rtl/edge_detector.sv
// edge_detector
// Single-bit rising/falling edge detector. One history flop (a_q) holds the
// level of a_i seen at the previous rising clk edge; the edge flags are a
// purely combinational compare of the live input against that history, so a
// transition is flagged in the same cycle it appears and is sampled high by
// downstream logic at exactly one rising clk edge.

module edge_detector #(
    // 1: reset is active-high (required setting). 0: active-low, kept for reuse.
    parameter bit ACTIVE_HIGH_RST = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic rising_edge_o,
    output logic falling_edge_o
);

    // Reset normalised to active-high regardless of the configured polarity.
    logic rst_active_s;

    // History of a_i as captured at the last rising clk edge.
    logic a_q;

    // Normalise the external reset polarity so the rest of the block sees an active-high reset.
    always_comb begin
        rst_active_s = 1'b0;
        if (ACTIVE_HIGH_RST) begin
            rst_active_s = reset;
        end else begin
            rst_active_s = ~reset;
        end
    end

    // History flop: cleared asynchronously by reset, otherwise tracks a_i every rising clk edge.
    always_ff @(posedge clk or posedge rst_active_s) begin
        if (rst_active_s) begin
            a_q <= 1'b0;
        end else begin
            a_q <= a_i;
        end
    end

    // Edge flags compare the live input against history; forced low while reset is held so a
    // high a_i during reset cannot leak a rising flag before release.
    always_comb begin
        rising_edge_o  = 1'b0;
        falling_edge_o = 1'b0;
        if (rst_active_s) begin
            rising_edge_o  = 1'b0;
            falling_edge_o = 1'b0;
        end else begin
            rising_edge_o  = a_i & ~a_q;
            falling_edge_o = ~a_i & a_q;
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Directed testbench for edge_detector. Clock period is 20 time units
// (rising edges at 10, 30, 50, ...). Inputs change on the falling edge;
// "pre" checks happen 2 units before the rising edge (the value a downstream
// sampler captures), "post" checks 2 units after it.

module tb_edge_detector;

    logic clk;
    logic reset;
    logic a_i;
    logic rising_edge_o;
    logic falling_edge_o;

    int checks;
    int errors;
    int rise_cnt;
    int fall_cnt;
    int both_cnt;

    edge_detector #(
        .ACTIVE_HIGH_RST(1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .a_i           (a_i),
        .rising_edge_o (rising_edge_o),
        .falling_edge_o(falling_edge_o)
    );

    // Free-running clock, period 20.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Wait from a falling edge to just before the next rising edge.
    task automatic to_pre();
        #8;
    endtask

    // Wait to just after the next rising edge.
    task automatic to_post();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        both_cnt = 0;
        reset    = 1'b1;
        a_i      = 1'b1;

        // ---------------- Reset held for 2 cycles with a_i=1 ----------------
        #2;
        chk("rst_t0_rise", rising_edge_o, 1'b0);
        chk("rst_t0_fall", falling_edge_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            to_pre();
            chk("rst_hold_rise", rising_edge_o, 1'b0);
            chk("rst_hold_fall", falling_edge_o, 1'b0);
        end

        // ---------------- Release with a_i=1: one rising pulse ----------------
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rel_rise_now", rising_edge_o, 1'b1);
        to_pre();
        chk("rel_rise_pre", rising_edge_o, 1'b1);
        chk("rel_fall_pre", falling_edge_o, 1'b0);
        to_post();
        chk("rel_rise_post", rising_edge_o, 1'b0);
        @(negedge clk);
        to_pre();
        chk("rel_rise_next", rising_edge_o, 1'b0);
        chk("rel_fall_next", falling_edge_o, 1'b0);

        // ---------------- Drop to 0 (falling), hold 2 cycles ----------------
        @(negedge clk);
        a_i = 1'b0;
        to_pre();
        chk("lo_fall_pre", falling_edge_o, 1'b1);
        chk("lo_rise_pre", rising_edge_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            to_pre();
            chk("lo_hold_rise", rising_edge_o, 1'b0);
            chk("lo_hold_fall", falling_edge_o, 1'b0);
        end

        // ---------------- Single rising edge ----------------
        @(negedge clk);
        a_i = 1'b1;
        to_pre();
        chk("sr_rise_pre", rising_edge_o, 1'b1);
        chk("sr_fall_pre", falling_edge_o, 1'b0);
        to_post();
        chk("sr_rise_post", rising_edge_o, 1'b0);
        @(negedge clk);
        to_pre();
        chk("sr_rise_next", rising_edge_o, 1'b0);
        chk("sr_fall_next", falling_edge_o, 1'b0);

        // ---------------- Single falling edge (a_i has been 1 for 2 cycles) ----------------
        @(negedge clk);
        a_i = 1'b0;
        to_pre();
        chk("sf_fall_pre", falling_edge_o, 1'b1);
        chk("sf_rise_pre", rising_edge_o, 1'b0);
        to_post();
        chk("sf_fall_post", falling_edge_o, 1'b0);
        @(negedge clk);
        to_pre();
        chk("sf_fall_next", falling_edge_o, 1'b0);
        chk("sf_rise_next", rising_edge_o, 1'b0);

        // ---------------- 5 periods: 2 cycles high, 2 cycles low ----------------
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    a_i = 1'b1;
                end else if (c == 2) begin
                    a_i = 1'b0;
                end
                to_pre();
                if (rising_edge_o === 1'b1) rise_cnt++;
                if (falling_edge_o === 1'b1) fall_cnt++;
                if (rising_edge_o === 1'b1 && falling_edge_o === 1'b1) both_cnt++;
            end
        end
        chk_int("multi_rise_count", rise_cnt, 5);
        chk_int("multi_fall_count", fall_cnt, 5);
        chk_int("multi_overlap", both_cnt, 0);

        // ---------------- Back-to-back toggling every cycle ----------------
        @(negedge clk);
        a_i = 1'b1;
        to_pre();
        chk("b2b_rise_1", rising_edge_o, 1'b1);
        @(negedge clk);
        a_i = 1'b0;
        to_pre();
        chk("b2b_fall_2", falling_edge_o, 1'b1);
        chk("b2b_rise_2", rising_edge_o, 1'b0);
        @(negedge clk);
        a_i = 1'b1;
        to_pre();
        chk("b2b_rise_3", rising_edge_o, 1'b1);
        chk("b2b_fall_3", falling_edge_o, 1'b0);
        @(negedge clk);
        a_i = 1'b0;
        to_pre();
        chk("b2b_fall_4", falling_edge_o, 1'b1);
        @(negedge clk);
        to_pre();
        chk("b2b_settle_fall", falling_edge_o, 1'b0);

        // ---------------- Quarter-period glitch between edges ----------------
        @(negedge clk);
        #2;
        a_i = 1'b1;
        #2;
        chk("gl_transient_rise", rising_edge_o, 1'b1);
        #3;
        a_i = 1'b0;
        #1;
        chk("gl_pre_rise", rising_edge_o, 1'b0);
        chk("gl_pre_fall", falling_edge_o, 1'b0);
        to_post();
        chk("gl_post_rise", rising_edge_o, 1'b0);
        chk("gl_post_fall", falling_edge_o, 1'b0);
        @(negedge clk);
        to_pre();
        chk("gl_next_fall", falling_edge_o, 1'b0);

        // ---------------- Async reset mid-pulse ----------------
        @(negedge clk);
        a_i = 1'b1;
        #2;
        chk("mp_rise_before", rising_edge_o, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mp_rise_dropped", rising_edge_o, 1'b0);
        chk("mp_fall_dropped", falling_edge_o, 1'b0);
        to_post();
        chk("mp_rise_in_rst", rising_edge_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("mp_rel_rise", rising_edge_o, 1'b1);
        to_pre();
        chk("mp_rel_rise_pre", rising_edge_o, 1'b1);
        to_post();
        chk("mp_rel_rise_post", rising_edge_o, 1'b0);
        @(negedge clk);
        to_pre();
        chk("mp_rel_rise_next", rising_edge_o, 1'b0);
        chk("mp_rel_fall_next", falling_edge_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
